// File: rtl/mpmc10_cache_fill.sv
// rtl/mpmc10_cache_fill.sv - cache line fill engine: read set, tag compare, dirty victim evict, set write-back
package mpmc10_pkg;
    localparam int CACHE_ASSOC    = 4;
    localparam int CACHE_TAG_BITS = 19;

    typedef struct packed {
        logic [CACHE_TAG_BITS-1:0] tag;
        logic                      modified;
        logic [127:0]              data;
    } mpmc10_cache_line_t;

    typedef struct packed {
        mpmc10_cache_line_t [CACHE_ASSOC-1:0] lines;
    } mpmc10_quad_cache_line_t;
endpackage

module mpmc10_cache_fill
    import mpmc10_pkg::*;
#(
    parameter int AMSB     = 28,
    parameter int IDX_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fill_valid_i,
    output logic                    fill_ready_o,
    input  logic [AMSB:0]           fill_adr_i,
    input  logic [127:0]            fill_dat_i,
    output logic                    ram_rd_o,
    output logic [IDX_BITS-1:0]     ram_adr_o,
    input  mpmc10_quad_cache_line_t ram_dat_i,
    output logic                    ram_we_o,
    output mpmc10_quad_cache_line_t ram_dat_o,
    output logic                    evict_valid_o,
    input  logic                    evict_ready_i,
    output logic [AMSB:0]           evict_adr_o,
    output logic [127:0]            evict_dat_o,
    output logic                    busy_o
);

    localparam int TAG_W = AMSB - IDX_BITS - 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RDSET = 3'd1,
        S_CMP   = 3'd2,
        S_EVICT = 3'd3,
        S_WRSET = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [AMSB:4]           adr_q, adr_d;
    logic [127:0]            dat_q, dat_d;
    mpmc10_quad_cache_line_t set_q, set_d;
    logic [1:0]              way_q, way_d;
    logic                    miss_q, miss_d;
    logic [1:0]              rr_q, rr_d;

    logic [TAG_W-1:0]        adr_tag;
    logic [IDX_BITS-1:0]     adr_idx;
    logic                    hit;
    logic [1:0]              hit_way;
    logic [1:0]              sel_way;
    logic                    sel_modified;
    logic                    unused_ok;

    assign adr_tag   = adr_q[AMSB:IDX_BITS+4];
    assign adr_idx   = adr_q[IDX_BITS+3:4];
    // Fills are whole lines; the byte offset carries no information here.
    assign unused_ok = ^fill_adr_i[3:0];

    // Descending scan so the lowest-numbered matching way is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = CACHE_ASSOC - 1; w >= 0; w--) begin
            if (ram_dat_i.lines[w].tag == adr_tag) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    assign sel_way      = hit ? hit_way : rr_q;
    assign sel_modified = ram_dat_i.lines[sel_way].modified;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q  <= '0;
            dat_q  <= '0;
            set_q  <= '0;
            way_q  <= '0;
            miss_q <= 1'b0;
            rr_q   <= '0;
        end else begin
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            set_q  <= set_d;
            way_q  <= way_d;
            miss_q <= miss_d;
            rr_q   <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (fill_valid_i) state_d = S_RDSET;
            S_RDSET: state_d = S_CMP;
            // A dirty hit is left alone so fill data never clobbers newer writes.
            S_CMP: begin
                if (sel_modified) state_d = hit ? S_IDLE : S_EVICT;
                else              state_d = S_WRSET;
            end
            S_EVICT: if (evict_ready_i) state_d = S_WRSET;
            S_WRSET: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        adr_d  = adr_q;
        dat_d  = dat_q;
        set_d  = set_q;
        way_d  = way_q;
        miss_d = miss_q;
        rr_d   = rr_q;
        case (state_q)
            S_IDLE: begin
                if (fill_valid_i) begin
                    adr_d = fill_adr_i[AMSB:4];
                    dat_d = fill_dat_i;
                end
            end
            S_CMP: begin
                set_d  = ram_dat_i;
                way_d  = sel_way;
                miss_d = !hit;
            end
            S_WRSET: begin
                if (miss_q) rr_d = rr_q + 2'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        fill_ready_o  = (state_q == S_IDLE);
        busy_o        = (state_q != S_IDLE);
        ram_rd_o      = (state_q == S_RDSET);
        ram_we_o      = (state_q == S_WRSET);
        evict_valid_o = (state_q == S_EVICT);
        ram_adr_o     = adr_idx;
        evict_adr_o   = {set_q.lines[way_q].tag, adr_idx, 4'h0};
        evict_dat_o   = set_q.lines[way_q].data;
        ram_dat_o     = set_q;
        ram_dat_o.lines[way_q].tag      = adr_tag;
        ram_dat_o.lines[way_q].modified = 1'b0;
        ram_dat_o.lines[way_q].data     = dat_q;
    end

endmodule

// File: tb/tb_mpmc10_cache_fill.sv
// tb/tb_mpmc10_cache_fill.sv - directed self-checking bench for mpmc10_cache_fill
module tb_mpmc10_cache_fill;
    import mpmc10_pkg::*;

    typedef mpmc10_quad_cache_line_t quad_t;
    typedef mpmc10_cache_line_t      line_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         fill_valid_i;
    logic         fill_ready_o;
    logic [28:0]  fill_adr_i;
    logic [127:0] fill_dat_i;
    logic         ram_rd_o;
    logic [5:0]   ram_adr_o;
    quad_t        ram_dat_i;
    logic         ram_we_o;
    quad_t        ram_dat_o;
    logic         evict_valid_o;
    logic         evict_ready_i;
    logic [28:0]  evict_adr_o;
    logic [127:0] evict_dat_o;
    logic         busy_o;

    mpmc10_cache_fill dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fill_valid_i (fill_valid_i),
        .fill_ready_o (fill_ready_o),
        .fill_adr_i   (fill_adr_i),
        .fill_dat_i   (fill_dat_i),
        .ram_rd_o     (ram_rd_o),
        .ram_adr_o    (ram_adr_o),
        .ram_dat_i    (ram_dat_i),
        .ram_we_o     (ram_we_o),
        .ram_dat_o    (ram_dat_o),
        .evict_valid_o(evict_valid_o),
        .evict_ready_i(evict_ready_i),
        .evict_adr_o  (evict_adr_o),
        .evict_dat_o  (evict_dat_o),
        .busy_o       (busy_o)
    );

    // Tag RAM stand-in: one-cycle read latency, plus a bench preload port.
    quad_t      mem [64];
    logic       pl_en = 1'b0;
    logic [5:0] pl_idx = '0;
    quad_t      pl_val = '0;

    always @(posedge clk) begin
        if (ram_rd_o) ram_dat_i <= mem[ram_adr_o];
        if (ram_we_o) mem[ram_adr_o] <= ram_dat_o;
        if (pl_en)    mem[pl_idx] <= pl_val;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic line_t mk(input logic [18:0] t, input logic m, input logic [127:0] d);
        line_t l;
        l.tag      = t;
        l.modified = m;
        l.data     = d;
        return l;
    endfunction

    function automatic logic [127:0] pat(input int idx, input int w);
        return {32'(idx), 32'(w), 64'hFEED_FACE_0BAD_F00D};
    endfunction

    function automatic quad_t mkset(input int idx, input logic [18:0] t0, input logic [18:0] t1,
                                    input logic [18:0] t2, input logic [18:0] t3, input logic [3:0] mods);
        quad_t q;
        q.lines[0] = mk(t0, mods[0], pat(idx, 0));
        q.lines[1] = mk(t1, mods[1], pat(idx, 1));
        q.lines[2] = mk(t2, mods[2], pat(idx, 2));
        q.lines[3] = mk(t3, mods[3], pat(idx, 3));
        return q;
    endfunction

    task automatic preload(input int idx, input quad_t v);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_val = v;
        @(posedge clk); #1;
        pl_en  = 1'b0;
    endtask

    int           r_we, r_idle, r_evn, r_rdn;
    quad_t        r_wdat;
    logic [28:0]  r_eadr;
    logic [127:0] r_edat;
    bit           r_estable, r_overlap, r_rdybusy;

    // Cycle 0 is the handshake cycle; later cycle numbers count rising edges from it.
    task automatic run_fill(input logic [28:0] a, input logic [127:0] d, input int stall);
        int cyc;
        r_we = -1; r_idle = -1; r_evn = 0; r_rdn = 0; r_wdat = '0;
        r_eadr = '0; r_edat = '0; r_estable = 1'b1; r_overlap = 1'b0; r_rdybusy = 1'b0;
        fill_valid_i = 1'b1;
        fill_adr_i   = a;
        fill_dat_i   = d;
        chk("fill_ready_idle", fill_ready_o, 1'b1);
        @(posedge clk); #1;
        fill_valid_i = 1'b0;
        cyc = 1;
        while (cyc < 40 && r_idle < 0) begin
            if (ram_rd_o && ram_we_o) r_overlap = 1'b1;
            if (busy_o && fill_ready_o) r_rdybusy = 1'b1;
            if (ram_rd_o) r_rdn++;
            if (ram_we_o) begin
                r_we   = cyc;
                r_wdat = ram_dat_o;
            end
            if (evict_valid_o) begin
                if (r_evn == 0) begin
                    r_eadr = evict_adr_o;
                    r_edat = evict_dat_o;
                end else if (evict_adr_o !== r_eadr || evict_dat_o !== r_edat) begin
                    r_estable = 1'b0;
                end
                r_evn++;
                evict_ready_i = (r_evn > stall);
            end else begin
                evict_ready_i = 1'b0;
            end
            if (!busy_o) r_idle = cyc;
            else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        evict_ready_i = 1'b0;
    endtask

    localparam logic [18:0] EMPTY = 19'h7FFFF;

    quad_t s_empty, s2, s3, s4, s5, s6, s7, s8, s20, s21, exp_q;
    bit    seen;
    int    cyc, k, n_acc, n_we;
    int    acc_cyc [4];
    int    we_idx  [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; fill_valid_i = 1'b0; fill_adr_i = '0; fill_dat_i = '0; evict_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_rd", ram_rd_o, 1'b0);
        chk("rst_we", ram_we_o, 1'b0);
        chk("rst_evict", evict_valid_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", fill_ready_o, 1'b1);

        // Empty set, first miss lands in way 0.
        s_empty = mkset(18, EMPTY, EMPTY, EMPTY, EMPTY, 4'b0000);
        preload(18, s_empty);
        run_fill(29'h0000_0120, {4{32'h1111_0001}}, 0);
        exp_q = s_empty;
        exp_q.lines[0] = mk(19'h0, 1'b0, {4{32'h1111_0001}});
        chk("t1_we_cyc", r_we, 3);
        chk("t1_idle_cyc", r_idle, 4);
        chk("t1_wdat", r_wdat, exp_q);
        chk("t1_rd_count", r_rdn, 1);
        chk("t1_no_evict", r_evn, 0);
        chk("t1_mem", mem[18], exp_q);
        chk("t1_no_overlap", r_overlap, 1'b0);
        chk("t1_ready_low_busy", r_rdybusy, 1'b0);

        // Clean hit in way 2.
        s2 = mkset(7, 19'h111, 19'h222, 19'h333, 19'h444, 4'b0000);
        preload(7, s2);
        run_fill({19'h333, 6'd7, 4'h0}, {4{32'h2222_0002}}, 0);
        exp_q = s2;
        exp_q.lines[2] = mk(19'h333, 1'b0, {4{32'h2222_0002}});
        chk("t2_we_cyc", r_we, 3);
        chk("t2_wdat", r_wdat, exp_q);

        // Dirty hit in way 1 beats a clean duplicate in way 3: nothing written.
        s3 = mkset(9, 19'h666, 19'h555, 19'h777, 19'h555, 4'b0010);
        preload(9, s3);
        run_fill({19'h555, 6'd9, 4'h3}, {4{32'h3333_0003}}, 0);
        chk("t3_no_we", r_we, -1);
        chk("t3_idle_cyc", r_idle, 3);
        chk("t3_no_evict", r_evn, 0);
        chk("t3_mem", mem[9], s3);

        // Pointer is still 1 after the two hits.
        s4 = mkset(10, EMPTY, EMPTY, EMPTY, EMPTY, 4'b0000);
        preload(10, s4);
        run_fill({19'h00010, 6'd10, 4'h0}, {4{32'h4444_0004}}, 0);
        exp_q = s4;
        exp_q.lines[1] = mk(19'h00010, 1'b0, {4{32'h4444_0004}});
        chk("t4_wdat_way1", r_wdat, exp_q);

        s5 = mkset(11, EMPTY, EMPTY, EMPTY, EMPTY, 4'b0000);
        preload(11, s5);
        run_fill({19'h00011, 6'd11, 4'h0}, {4{32'h5555_0005}}, 0);
        exp_q = s5;
        exp_q.lines[2] = mk(19'h00011, 1'b0, {4{32'h5555_0005}});
        chk("t5_wdat_way2", r_wdat, exp_q);

        // Dirty victim in way 3 with four stalled cycles.
        s6 = mkset(5, 19'h100, 19'h200, 19'h300, 19'h00ABC, 4'b1000);
        preload(5, s6);
        run_fill({19'h00123, 6'd5, 4'h0}, {4{32'h6666_0006}}, 4);
        exp_q = s6;
        exp_q.lines[3] = mk(19'h00123, 1'b0, {4{32'h6666_0006}});
        chk("t6_evict_adr", r_eadr, 29'h02AF050);
        chk("t6_evict_dat", r_edat, pat(5, 3));
        chk("t6_evict_cycles", r_evn, 5);
        chk("t6_evict_stable", r_estable, 1'b1);
        chk("t6_we_cyc", r_we, 8);
        chk("t6_idle_cyc", r_idle, 9);
        chk("t6_wdat", r_wdat, exp_q);
        chk("t6_no_overlap", r_overlap, 1'b0);

        // Pointer wrapped 3 -> 0.
        s7 = mkset(12, EMPTY, EMPTY, EMPTY, EMPTY, 4'b0000);
        preload(12, s7);
        run_fill({19'h00042, 6'd12, 4'h0}, {4{32'h7777_0007}}, 0);
        exp_q = s7;
        exp_q.lines[0] = mk(19'h00042, 1'b0, {4{32'h7777_0007}});
        chk("t7_wdat_wrap", r_wdat, exp_q);

        // Reset while offering a dirty victim (pointer 1, way 1 dirty).
        s8 = mkset(13, 19'h1, 19'h2, 19'h3, 19'h4, 4'b0010);
        preload(13, s8);
        fill_valid_i = 1'b1;
        fill_adr_i   = {19'h00099, 6'd13, 4'h0};
        fill_dat_i   = {4{32'h8888_0008}};
        @(posedge clk); #1;
        fill_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t8_in_evict", evict_valid_o, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t8_evict_drop", evict_valid_o, 1'b0);
        chk("t8_busy_drop", busy_o, 1'b0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (ram_we_o || evict_valid_o) seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (ram_we_o || evict_valid_o) seen = 1'b1;
        end
        chk("t8_nothing_after_reset", seen, 1'b0);
        chk("t8_mem_untouched", mem[13], s8);

        preload(18, s_empty);
        run_fill(29'h0000_0120, {4{32'h9999_0009}}, 0);
        exp_q = s_empty;
        exp_q.lines[0] = mk(19'h0, 1'b0, {4{32'h9999_0009}});
        chk("t8_refill_we_cyc", r_we, 3);
        chk("t8_refill_wdat", r_wdat, exp_q);

        // Back-to-back with fill_valid_i held high; pointer is 1.
        s20 = mkset(20, EMPTY, EMPTY, EMPTY, EMPTY, 4'b0000);
        s21 = mkset(21, EMPTY, EMPTY, EMPTY, EMPTY, 4'b0000);
        preload(20, s20);
        preload(21, s21);
        fill_valid_i = 1'b1;
        fill_adr_i   = {19'h00020, 6'd20, 4'h0};
        fill_dat_i   = {4{32'hAAAA_000A}};
        k = 0; n_acc = 0; n_we = 0; cyc = 0;
        while (cyc < 40 && (k < 2 || busy_o)) begin
            if (ram_we_o && n_we < 4) begin
                we_idx[n_we] = int'(ram_adr_o);
                n_we++;
            end
            if (fill_valid_i && fill_ready_o && n_acc < 4) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                k++;
            end
            @(posedge clk); #1;
            cyc++;
            if (k == 1) begin
                fill_adr_i = {19'h00021, 6'd21, 4'h0};
                fill_dat_i = {4{32'hBBBB_000B}};
            end
            if (k >= 2) fill_valid_i = 1'b0;
        end
        fill_valid_i = 1'b0;
        chk("t9_accepts", n_acc, 2);
        chk("t9_accept_gap", acc_cyc[1] - acc_cyc[0], 4);
        chk("t9_writes", n_we, 2);
        chk("t9_we_idx0", we_idx[0], 20);
        chk("t9_we_idx1", we_idx[1], 21);
        chk("t9_mem20", mem[20].lines[1], mk(19'h00020, 1'b0, {4{32'hAAAA_000A}}));
        chk("t9_mem21", mem[21].lines[2], mk(19'h00021, 1'b0, {4{32'hBBBB_000B}}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
